spi_ram_arbiter: RTL

Command decoder and single-port RAM arbiter between the SPI slave and a local host port. It decodes the 10-bit SPI frames (`rx_data`/`rx_valid`) into RAM write and read operations and returns read bytes to the slave on `tx_data`/`tx_valid`. It shares one single-port synchronous RAM between the SPI path and a local host port using round-robin arbitration.

---
 rtl/spi_ram_arbiter_if.sv | 44 ++++
 rtl/spi_ram_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of the SPI frame, host port and RAM port signals of spi_ram_arbiter.
// The arbiter connects through the master modport; the environment (SPI slave,
// host and RAM) connects through the slave modport.
interface spi_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // SPI slave side
    logic              rx_valid;
    logic [9:0]        rx_data;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;

    // Local host port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    // Single-port synchronous RAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              spi_ovf;

    modport master (
        input  rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, mem_rdata,
        output tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, spi_ovf
    );

    modport slave (
        output rx_valid, rx_data, host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  tx_valid, tx_data, host_gnt, host_rvalid, host_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, spi_ovf
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and round-robin arbiter in front of one single-port RAM.
// 10-bit SPI frames set the write/read address or queue one write/read op;
// a local host port competes for the same RAM. Reads return on tx_data (SPI)
// or host_rdata (host). ADDR_W and DATA_W must both equal the 8-bit payload.
module spi_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD      = 2'b11
    } cmd_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    // Control state
    state_t            state_q;
    logic              rx_valid_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              spi_pend_q;
    op_t               spi_op_q;
    logic              prio_q;      // 1: host wins a collision
    logic              cur_spi_q;   // op in flight belongs to the SPI side
    logic              cur_we_q;    // op in flight is a write

    // Registered outputs
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              host_gnt_q;
    logic              host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              tx_valid_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              spi_ovf_q;

    // Frame decode helpers
    logic              frame_start;
    cmd_t              cmd;
    logic [7:0]        payload;

    // Arbitration result for the current cycle
    logic              spi_win;
    logic              host_win;
    op_t               grant_op;

    assign frame_start = bus.rx_valid && !rx_valid_q;
    assign cmd         = cmd_t'(bus.rx_data[9:8]);
    assign payload     = bus.rx_data[7:0];

    // Pick the winner among pending requests; requests only count in IDLE.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        spi_win  = 1'b0;
        host_win = 1'b0;
        grant_op = spi_op_q;
        if (state_q == IDLE) begin
            if (spi_pend_q && (!bus.host_req || !prio_q)) begin
                spi_win = 1'b1;
            end else if (bus.host_req) begin
                host_win      = 1'b1;
                grant_op.we   = bus.host_we;
                grant_op.addr = bus.host_addr;
                grant_op.data = bus.host_wdata;
            end
        end
    end

    // Access FSM, frame decoder and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rx_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            spi_pend_q    <= 1'b0;
            spi_op_q      <= '0;
            prio_q        <= 1'b0;
            cur_spi_q     <= 1'b0;
            cur_we_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            spi_ovf_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment to the
            // same register in this block (spi_pend_q below) takes precedence.
            rx_valid_q    <= bus.rx_valid;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            tx_valid_q    <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (spi_win || host_win) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_op.we;
                        mem_addr_q  <= grant_op.addr;
                        mem_wdata_q <= grant_op.data;
                        cur_spi_q   <= spi_win;
                        cur_we_q    <= grant_op.we;
                        prio_q      <= spi_win;
                        host_gnt_q  <= host_win;
                        if (spi_win) begin
                            spi_pend_q <= 1'b0;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= cur_we_q ? IDLE : RDATA;
                end
                RDATA: begin
                    if (cur_spi_q) begin
                        tx_data_q  <= bus.mem_rdata;
                        tx_valid_q <= 1'b1;
                    end else begin
                        host_rdata_q  <= bus.mem_rdata;
                        host_rvalid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // One decode per rising edge of rx_valid. The op slot counts as free
            // if it is empty or is being granted in this very cycle.
            if (frame_start) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr_q <= ADDR_W'(payload);
                    CMD_RD_ADDR: rd_addr_q <= ADDR_W'(payload);
                    CMD_WR_DATA, CMD_RD: begin
                        if (!spi_pend_q || spi_win) begin
                            spi_pend_q    <= 1'b1;
                            spi_op_q.we   <= (cmd == CMD_WR_DATA);
                            spi_op_q.addr <= (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;
                            // Reads carry the payload too; it only reaches mem_wdata,
                            // which the RAM ignores when mem_we is low.
                            spi_op_q.data <= DATA_W'(payload);
                        end else begin
                            spi_ovf_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.spi_ovf     = spi_ovf_q;
endmodule
